// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin hold arbiter.
// Holds the FSM state enum and the index-width helper.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_OWNED
    } arb_state_t;

    // A one-requester-wide index would otherwise get a zero-width bus
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker.
// Returns the first set request at or after ptr, wrapping modulo N.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    int k;

    // Scan from the farthest offset down so the nearest hit wins last
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        k     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            k = int'(ptr) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (req[k]) begin
                valid = 1'b1;
                idx   = IW'(k);
            end
        end
    end

endmodule

// File: rtl/rr_hold_arb.sv
// N-way round-robin arbiter with grant hold, explicit release and hold limit.
// All outputs come straight from flops.
module rr_hold_arb
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16,
    localparam int IW      = idx_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  done,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id,
    output logic          busy,
    output logic          timeout
);

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
    localparam logic [7:0] HOLD_SAT = (MAX_HOLD == 0) ? 8'hFF : 8'(MAX_HOLD);

    arb_state_t    state, state_n;
    logic [IW-1:0] ptr, ptr_n;
    logic [7:0]    hcnt, hcnt_n;
    logic [N-1:0]  gnt_n;
    logic [IW-1:0] gnt_id_n;
    logic          busy_n, timeout_n;
    logic          user_rel, limit_rel;
    logic          pick_valid;
    logic [IW-1:0] pick_idx;

    rr_pick #(.N(N)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ARB_IDLE;
            ptr     <= '0;
            hcnt    <= '0;
            gnt     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            hcnt    <= hcnt_n;
            gnt     <= gnt_n;
            gnt_id  <= gnt_id_n;
            busy    <= busy_n;
            timeout <= timeout_n;
        end
    end

    // Owner-initiated release outranks the hold limit, so it also masks timeout
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        hcnt_n    = hcnt;
        gnt_n     = gnt;
        gnt_id_n  = gnt_id;
        busy_n    = busy;
        timeout_n = 1'b0;
        user_rel  = done[gnt_id] | ~req[gnt_id];
        limit_rel = (MAX_HOLD != 0) && (hcnt == HOLD_LIM);

        case (state)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_n  = ARB_OWNED;
                    gnt_n    = N'(1) << pick_idx;
                    gnt_id_n = pick_idx;
                    busy_n   = 1'b1;
                    hcnt_n   = 8'd1;
                end
            end
            ARB_OWNED: begin
                if (user_rel || limit_rel) begin
                    state_n   = ARB_IDLE;
                    gnt_n     = '0;
                    gnt_id_n  = '0;
                    busy_n    = 1'b0;
                    hcnt_n    = '0;
                    ptr_n     = (gnt_id == IW'(N - 1)) ? '0 : gnt_id + IW'(1);
                    timeout_n = ~user_rel;
                end else if (hcnt != HOLD_SAT) begin
                    hcnt_n = hcnt + 8'd1;
                end
            end
            default: begin
                state_n = ARB_IDLE;
            end
        endcase
    end

endmodule

// File: doc/rr_hold_arb.md
# rr_hold_arb

N-way round-robin arbiter with grant hold, explicit release, and hold-time limit for a shared single-owner resource, such as a shared bus port or memory bank. It generalises the two-requester alternating-priority arbiter into an N-requester lock controller. A granted requester keeps ownership across multiple cycles until it releases the resource or hits the hold limit. Fairness comes from a rotating priority pointer that advances past each owner on release.

## Interface
Parameters:
- N, 4: number of requesters; legal range 2..16.
- MAX_HOLD, 16: maximum consecutive cycles one grant may last; 0 disables the limit; legal range 0..255.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  N  per-requester request level; held high while the requester wants or holds the resource.
- done  in  N  per-requester release strobe; only done[owner] has effect.
- gnt  out  N  registered grant; one-hot or zero.
- gnt_id  out  $clog2(N)  index of the current owner; valid when busy=1, else 0.
- busy  out  1  high iff gnt != 0.
- timeout  out  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

## Operation
- FSM with two states:
  - IDLE: no owner.
  - OWNED: gnt[owner]=1.
- IDLE, req != 0 → OWNED.
  - owner = first set bit of req, searching from index ptr upward, wrapping modulo N.
  - Hold counter hcnt loads 1.
- IDLE, req == 0 → stay in IDLE.
- OWNED: release when any of these is true, evaluated each cycle:
  - done[owner]=1
  - req[owner]=0
  - MAX_HOLD != 0 and hcnt == MAX_HOLD
- OWNED, no release: stay in OWNED; hcnt increments, saturating at MAX_HOLD.
- On release:
  - Go to IDLE.
  - ptr ← (owner+1) mod N.
  - If the release was caused only by the hold limit (done[owner]=0 and req[owner]=1), timeout=1 in the next cycle.
- Simultaneous causes: done or req-drop takes precedence over the limit. A limit release coinciding with done gives timeout=0.
- done for non-owners and done in IDLE are ignored.
- New req bits arriving during OWNED have no effect until IDLE.
- A force-released requester that keeps req high is eligible again. Because ptr has advanced, it has lowest priority.
- Reset values: state=IDLE, ptr=0, hcnt=0, gnt=0, gnt_id=0, busy=0, timeout=0.
- Reset mid-grant drops gnt asynchronously. No timeout pulse is produced.

## Timing
- Grant latency: req sampled high at edge t → gnt high after edge t+1.
- Release latency: release condition sampled at edge t → gnt low after edge t+1.
- Turnaround: at least one cycle with gnt=0 between any two grants, including re-grant to the same requester.
- Maximum gnt high time: MAX_HOLD cycles.
- Worst-case wait for a continuously requesting requester: (N-1)·(MAX_HOLD+1) cycles after its first IDLE opportunity.
- timeout is asserted in the same cycle gnt first reads 0 after a forced release, and lasts exactly 1 cycle.
- gnt, gnt_id, busy and timeout are all driven directly from flops; no combinational path from inputs to outputs.

## Structure
- Shared package arb_pkg holds:
  - the state enum (ARB_IDLE, ARB_OWNED);
  - a function returning $clog2 with a minimum of 1, used for index widths.
- Sub-module rr_pick (purely combinational), with parameter N:
  - inputs: req[N], ptr[idx width]
  - outputs: valid, idx
  - idx is the first set bit of req at or after ptr, wrapping.
- The top level holds the FSM, ptr, hcnt and output registers.

## Test plan
All scenarios use N=4, MAX_HOLD=4 unless stated.
- Reset, then req=4'b0101 held → gnt=0001, gnt_id=0 one cycle later. Pulse done[0] → gnt=0 for one cycle, then gnt=0100, gnt_id=2.
- All four req high, each owner pulses done on its 2nd grant cycle → grant order 0,1,2,3,0. Each gnt lasts 2 cycles with 1 idle cycle between.
- req=4'b0010 held, done never asserted → gnt=0010 for exactly 4 cycles, then gnt=0 with timeout=1 for 1 cycle. Grant 0010 returns the following cycle.
- Owner 1 asserts done in the same cycle hcnt==4 → gnt drops with timeout=0. Pulsing done[3] while owner=1 has no effect.
- Owner drops req mid-grant at cycle 2 → gnt=0 next cycle, no timeout, ptr advances to owner+1.
- Assert rst while gnt=1000 → all outputs 0 immediately. After reset, req=4'b1001 gives gnt=0001 (ptr=0). Repeat with MAX_HOLD=0: a grant held 300 cycles never times out.
